// File: rtl/tinyml_pkg.sv
// Shared types and defaults for the tinyml tile datapath.
package tinyml_pkg;

    localparam int DEFAULT_TILE_WIDTH = 256;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // A bank can take new tiles only before it has been closed.
    function automatic logic is_writable(input bank_state_t s);
        return (s == EMPTY) || (s == FILLING);
    endfunction

endpackage

// File: rtl/tile_bank_mem.sv
// Simple dual-port tile storage for both ping-pong banks.
// Address is {bank, ptr}; synchronous write, registered one-cycle read.
module tile_bank_mem
    import tinyml_pkg::*;
#(
    parameter int TILE_WIDTH = DEFAULT_TILE_WIDTH,
    parameter int AW         = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [TILE_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [TILE_WIDTH-1:0] rdata_o
);

    logic [TILE_WIDTH-1:0] mem_q [0:(1<<AW)-1];
    logic [TILE_WIDTH-1:0] rdata_q;

    // Storage array: written on accepted tiles, never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register: loads only on an accepted request, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tile_buffer.sv
// Ping-pong tile buffer: the loader fills one bank while the compute side
// drains the other. Bank state/pointer control lives here; storage is in
// tile_bank_mem.
module tile_buffer
    import tinyml_pkg::*;
#(
    parameter int TILE_WIDTH = DEFAULT_TILE_WIDTH,
    parameter int DEPTH      = 16,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_tile,
    input  logic [TILE_WIDTH-1:0] wr_data,
    input  logic                  wr_done,
    output logic                  wr_ready,
    output logic                  rd_avail,
    output logic [CW-1:0]         rd_count,
    input  logic                  rd_start,
    input  logic                  rd_req,
    output logic [TILE_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  overflow
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

    bank_state_t   bank_q  [2];
    bank_state_t   bank_d  [2];
    logic [CW-1:0] count_q [2];
    logic [CW-1:0] count_d [2];

    logic          wr_bank_q, wr_bank_d;
    logic [CW-1:0] wr_ptr_q,  wr_ptr_d;
    logic          rd_bank_q, rd_bank_d;
    logic [CW-1:0] rd_ptr_q,  rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q,  rd_last_d;

    bank_state_t   wr_state_s;
    bank_state_t   rd_state_s;
    logic [CW-1:0] rd_cnt_s;
    logic          wr_space_s;
    logic          wr_accept_s;
    logic          wr_close_s;
    logic          rd_claim_s;
    logic          rd_fire_s;
    logic          rd_fire_last_s;

    // Decode which write/read events are legal this cycle.
    always_comb begin
        wr_state_s  = bank_q[wr_bank_q];
        rd_state_s  = bank_q[rd_bank_q];
        rd_cnt_s    = count_q[rd_bank_q];
        wr_space_s  = (wr_ptr_q < DEPTH_C);
        wr_accept_s = wr_tile && is_writable(wr_state_s) && wr_space_s;
        // A same-cycle accepted tile makes an EMPTY bank closable too.
        wr_close_s  = wr_done && ((wr_state_s == FILLING) || wr_accept_s);
        rd_claim_s  = rd_start && (rd_state_s == FULL);
        rd_fire_s   = rd_req && (rd_state_s == DRAINING) && (rd_ptr_q < rd_cnt_s);
        rd_fire_last_s = rd_fire_s && (rd_ptr_q == (rd_cnt_s - ONE_C));
    end

    // Next-state for bank FSMs, pointers and sticky overflow.
    always_comb begin
        bank_d     = bank_q;
        count_d    = count_q;
        wr_bank_d  = wr_bank_q;
        wr_ptr_d   = wr_ptr_q;
        rd_bank_d  = rd_bank_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        rd_valid_d = rd_fire_s;
        rd_last_d  = rd_fire_last_s;

        if (wr_accept_s) begin
            bank_d[wr_bank_q] = FILLING;
            wr_ptr_d          = wr_ptr_q + ONE_C;
        end else if (wr_tile) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        // Close after the store so a coincident tile is counted.
        if (wr_close_s) begin
            bank_d[wr_bank_q]  = FULL;
            count_d[wr_bank_q] = wr_ptr_q + {{(CW-1){1'b0}}, wr_accept_s};
            wr_bank_d          = ~wr_bank_q;
            wr_ptr_d           = '0;
        end else begin
            wr_bank_d = wr_bank_q;
        end

        // Read side only ever touches FULL/DRAINING banks, so it cannot
        // collide with the write-side updates above.
        if (rd_claim_s) begin
            bank_d[rd_bank_q] = DRAINING;
            rd_ptr_d          = '0;
        end else if (rd_fire_s) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end else if (rd_last_q) begin
            // Release the bank once its final tile has been presented.
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State register with asynchronous reset to all-EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b]  <= EMPTY;
                count_q[b] <= '0;
            end
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            bank_q     <= bank_d;
            count_q    <= count_d;
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    tile_bank_mem #(
        .TILE_WIDTH (TILE_WIDTH),
        .AW         (PW + 1)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr_accept_s),
        .waddr_i ({wr_bank_q, wr_ptr_q[PW-1:0]}),
        .wdata_i (wr_data),
        .re_i    (rd_fire_s),
        .raddr_i ({rd_bank_q, rd_ptr_q[PW-1:0]}),
        .rdata_o (rd_data)
    );

    assign wr_ready = is_writable(wr_state_s) && wr_space_s;
    assign rd_avail = (rd_state_s == FULL);
    assign rd_count = ((rd_state_s == FULL) || (rd_state_s == DRAINING)) ? rd_cnt_s : '0;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_tile_buffer.sv
// Directed bench for tile_buffer with a read-data scoreboard.
module tb_tile_buffer;

    localparam int TW    = 256;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_tile;
    logic [TW-1:0] wr_data;
    logic          wr_done;
    logic          wr_ready;
    logic          rd_avail;
    logic [CW-1:0] rd_count;
    logic          rd_start;
    logic          rd_req;
    logic [TW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_last;
    logic          overflow;

    typedef struct {
        logic [TW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    tile_buffer #(.TILE_WIDTH(TW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_tile  (wr_tile),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .wr_ready (wr_ready),
        .rd_avail (rd_avail),
        .rd_count (rd_count),
        .rd_start (rd_start),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_last  (rd_last),
        .overflow (overflow)
    );

    function automatic logic [TW-1:0] tile_val(input int ld, input int idx);
        logic [31:0] w;
        w = {8'hA5, 8'(ld), 8'h3C, 8'(idx)};
        return {(TW/32){w}};
    endfunction

    task automatic check_data(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rd_valid must match the oldest expected tile.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_errors++;
                $error("FAIL unexpected_rd_valid: observed rd_valid=1 expected 0");
            end
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check_data("rd_data", rd_data, e.data);
                check_val("rd_last", int'(rd_last), int'(e.last));
            end
        end
    end

    task automatic wr(input int ld, input int idx, input bit done);
        wr_tile = 1'b1;
        wr_data = tile_val(ld, idx);
        wr_done = done;
        @(negedge clk);
        wr_tile = 1'b0;
        wr_done = 1'b0;
    endtask

    task automatic pulse_done();
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
    endtask

    task automatic pulse_start();
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
    endtask

    // Back-to-back requests; one cycle latency means the queue is empty
    // right after the final request cycle.
    task automatic read_burst(input int ld, input int n, input int cnt);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{tile_val(ld, i), (i == cnt - 1)});
            rd_req = 1'b1;
            @(negedge clk);
        end
        rd_req = 1'b0;
        #1;
        check_val("burst_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_data({tag, "_rd_data"}, rd_data, '0);
        check_val({tag, "_rd_valid"}, int'(rd_valid), 0);
        check_val({tag, "_rd_last"}, int'(rd_last), 0);
        check_val({tag, "_overflow"}, int'(overflow), 0);
        check_val({tag, "_rd_avail"}, int'(rd_avail), 0);
        check_val({tag, "_rd_count"}, int'(rd_count), 0);
        check_val({tag, "_wr_ready"}, int'(wr_ready), 1);
    endtask

    initial begin
        rst = 1'b1; wr_tile = 1'b0; wr_data = '0; wr_done = 1'b0;
        rd_start = 1'b0; rd_req = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic fill/drain of three tiles.
        for (int i = 0; i < 3; i++) wr(1, i, 1'b0);
        pulse_done();
        check_val("basic_rd_avail", int'(rd_avail), 1);
        check_val("basic_rd_count", int'(rd_count), 3);
        pulse_start();
        check_val("basic_avail_draining", int'(rd_avail), 0);
        read_burst(1, 3, 3);
        @(negedge clk);
        check_val("basic_post_rd_avail", int'(rd_avail), 0);
        check_val("basic_post_wr_ready", int'(wr_ready), 1);
        check_val("basic_post_rd_count", int'(rd_count), 0);

        // wr_tile coincident with wr_done is stored and counted.
        for (int i = 0; i < 3; i++) wr(2, i, 1'b0);
        wr(2, 3, 1'b1);
        check_val("coinc_rd_count", int'(rd_count), 4);
        pulse_start();
        read_burst(2, 4, 4);
        @(negedge clk);

        // Overlap: drain bank 0 while loading 5 tiles into bank 1.
        wr(3, 0, 1'b0);
        wr(3, 1, 1'b0);
        pulse_done();
        check_val("ovl_rd_count0", int'(rd_count), 2);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            wr_tile = 1'b1;
            wr_data = tile_val(4, i);
            wr_done = (i == 4);
            if (i < 2) begin
                exp_q.push_back('{tile_val(3, i), (i == 1)});
                rd_req = 1'b1;
            end else begin
                rd_req = 1'b0;
            end
            @(negedge clk);
        end
        wr_tile = 1'b0; wr_done = 1'b0; rd_req = 1'b0;
        #1;
        check_val("ovl_drained", exp_q.size(), 0);
        check_val("ovl_rd_avail1", int'(rd_avail), 1);
        check_val("ovl_rd_count1", int'(rd_count), 5);
        pulse_start();
        read_burst(4, 5, 5);
        @(negedge clk);

        // Overflow: 17 tiles into a 16-deep bank.
        for (int i = 0; i < 16; i++) wr(5, i, 1'b0);
        check_val("ovf_full_wr_ready", int'(wr_ready), 0);
        check_val("ovf_before", int'(overflow), 0);
        wr(5, 16, 1'b0);
        check_val("ovf_set", int'(overflow), 1);
        pulse_done();
        check_val("ovf_rd_count", int'(rd_count), 16);
        wr(6, 0, 1'b1);
        check_val("both_full_wr_ready", int'(wr_ready), 0);
        wr(6, 1, 1'b0);
        check_val("both_full_overflow", int'(overflow), 1);
        check_val("both_full_wr_ready2", int'(wr_ready), 0);
        pulse_start();
        read_burst(5, 16, 16);
        @(negedge clk);
        check_val("bank1_rd_avail", int'(rd_avail), 1);
        check_val("bank1_rd_count", int'(rd_count), 1);
        pulse_start();
        read_burst(6, 1, 1);
        @(negedge clk);

        // Ignored controls: no rd_valid and no state change.
        rd_req = 1'b1;
        repeat (2) @(negedge clk);
        rd_req = 1'b0;
        pulse_start();
        rd_req = 1'b1;
        repeat (2) @(negedge clk);
        rd_req = 1'b0;
        pulse_done();
        check_val("ign_rd_avail", int'(rd_avail), 0);
        check_val("ign_rd_count", int'(rd_count), 0);
        check_val("ign_wr_ready", int'(wr_ready), 1);
        check_val("ign_overflow_sticky", int'(overflow), 1);
        wr(7, 0, 1'b1);
        check_val("ign_load_rd_count", int'(rd_count), 1);
        pulse_start();
        read_burst(7, 1, 1);
        @(negedge clk);

        // Reset in the middle of draining a 4-tile bank.
        for (int i = 0; i < 4; i++) wr(8, i, 1'b0);
        pulse_done();
        pulse_start();
        read_burst(8, 1, 4);
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("postrst_wr_ready", int'(wr_ready), 1);
        check_val("postrst_rd_avail", int'(rd_avail), 0);
        wr(9, 0, 1'b0);
        wr(9, 1, 1'b1);
        check_val("postrst_rd_count", int'(rd_count), 2);
        pulse_start();
        read_burst(9, 2, 2);
        repeat (4) @(negedge clk);
        check_val("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
